// File: rtl/booth_seq_pkg.sv
// rtl/booth_seq_pkg.sv - shared types and constants for the Booth multiplier issue sequencer
package booth_seq_pkg;

    localparam int OPND_W          = 8;
    localparam int PROD_W          = 16;
    localparam int TIMEOUT_DEFAULT = 24;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/booth_issue_ctrl.sv
// rtl/booth_issue_ctrl.sv - operand issue / result collection sequencer for the Booth multiplier
// Optional WAIT-state timeout with out_error port: define BOOTH_TIMEOUT_EN.
module booth_issue_ctrl
    import booth_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_multiplicand,
    input  logic [OPND_W-1:0] in_multiplier,
    output logic              mul_rst,
    output logic [OPND_W-1:0] mul_multiplicand,
    output logic [OPND_W-1:0] mul_multiplier,
    input  logic [PROD_W-1:0] mul_product,
    input  logic              mul_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              busy
`ifdef BOOTH_TIMEOUT_EN
    ,
    output logic              out_error
`endif
);

    if (2**CNT_W <= TIMEOUT_CYCLES) begin : g_cfg_chk
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t state, state_next;
    logic   accept;
    logic   capture;
    logic   timeout;

`ifdef BOOTH_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START:  state_next = SETTLE;
            // A done still high from the previous operation is ignored here.
            SETTLE: state_next = WAIT;
            WAIT: begin
                if (mul_done) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
`ifdef BOOTH_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout    = 1'b1;
                    state_next = HOLD;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            out_product      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                mul_multiplicand <= in_multiplicand;
                mul_multiplier   <= in_multiplier;
            end
            if (capture) begin
                out_product <= mul_product;
            end else if (timeout) begin
                out_product <= '0;
            end
        end
    end

`ifdef BOOTH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            out_error <= 1'b0;
        end else begin
            if (state == SETTLE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                out_error <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_error <= 1'b0;
            end
        end
    end
`endif

    // Multiplier stays in reset for the whole of system reset, not just START.
    assign mul_rst   = rst | (state == START);
    assign in_ready  = !rst && ((state == IDLE) || (state == HOLD && out_ready));
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// tb/tb_booth_issue_ctrl.sv - directed-vector bench for booth_issue_ctrl with a behavioural multiplier
module tb_booth_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_multiplicand;
    logic [7:0]  in_multiplier;
    logic        mul_rst;
    logic [7:0]  mul_multiplicand;
    logic [7:0]  mul_multiplier;
    logic [15:0] mul_product;
    logic        mul_done;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        busy;
`ifdef BOOTH_TIMEOUT_EN
    logic        out_error;
`endif

    int vectors     = 0;
    int miscompares = 0;

    booth_issue_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .mul_rst          (mul_rst),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .busy             (busy)
`ifdef BOOTH_TIMEOUT_EN
        ,
        .out_error        (out_error)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: done 4 cycles after reset releases.
    // stale_mode keeps the old done/product through the first post-reset cycle.
    bit          stale_mode = 1'b0;
    bit          hang_mode  = 1'b0;
    logic [3:0]  m_cnt  = '0;
    logic        m_run  = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_prod = '0;

    always @(posedge clk) begin
        if (mul_rst) begin
            m_run <= 1'b1;
            m_cnt <= '0;
            if (!stale_mode) m_done <= 1'b0;
        end else if (m_run) begin
            m_done <= 1'b0;
            if (!hang_mode) begin
                m_cnt <= m_cnt + 1'b1;
                if (m_cnt == 4'd3) begin
                    m_done <= 1'b1;
                    m_prod <= $signed(mul_multiplicand) * $signed(mul_multiplier);
                    m_run  <= 1'b0;
                end
            end
        end
    end

    assign mul_done    = m_done;
    assign mul_product = m_prod;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        in_multiplicand = a;
        in_multiplier   = b;
        in_valid        = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready_drain"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        bit ok;
        start_op(a, b);
        wait_valid(ok);
        check({tag, "_done"}, 32'(ok), 32'd1);
        check(tag, 32'(out_product), 32'(exp));
        drain(tag);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t corners[4] = '{
        '{8'h80, 8'h80, 16'h4000},
        '{8'h7F, 8'h80, 16'hC080},
        '{8'h00, 8'h55, 16'h0000},
        '{8'hFF, 8'h01, 16'hFFFF}
    };

    initial begin
        bit ok;
        bit stable;
        bit seen;
        int rst_cnt;
        int n;

        rst             = 1'b1;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        out_ready       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_product", 32'(out_product), 32'd0);
        check("rst_mcand", 32'(mul_multiplicand), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mul_rst", 32'(mul_rst), 32'd1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_mul_rst", 32'(mul_rst), 32'd0);

        // 7 x -3 with latency, mul_rst width and operand stability
        start_op(8'h07, 8'hFD);
        check("start_mul_rst", 32'(mul_rst), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd0);
        check("start_mcand", 32'(mul_multiplicand), 32'h07);
        check("start_mplier", 32'(mul_multiplier), 32'hFD);
        rst_cnt = 1;
        stable  = 1'b1;
        @(posedge clk); #1;
        check("settle_mul_rst", 32'(mul_rst), 32'd0);
        check("settle_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 60 && !out_valid; i++) begin
            if (mul_rst) rst_cnt++;
            if (mul_multiplicand != 8'h07 || mul_multiplier != 8'hFD || in_ready) stable = 1'b0;
            @(posedge clk); #1;
        end
        check("op1_done", 32'(out_valid), 32'd1);
        check("op1_mul_rst_cycles", 32'(rst_cnt), 32'd1);
        check("op1_operands_stable", 32'(stable), 32'd1);
        check("op1_product", 32'(out_product), 32'hFFEB);
        drain("op1");

        foreach (corners[i])
            run_op($sformatf("corner%0d", i), corners[i].a, corners[i].b, corners[i].p);

        // Backpressure with a pending pair, then retire and accept together
        start_op(8'h03, 8'h05);
        wait_valid(ok);
        check("bp_done", 32'(ok), 32'd1);
        in_multiplicand = 8'h02;
        in_multiplier   = 8'h06;
        in_valid        = 1'b1;
        stable          = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (out_product != 16'h000F || in_ready || !out_valid || mul_multiplicand != 8'h03)
                stable = 1'b0;
            @(posedge clk); #1;
        end
        check("bp_hold_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_next_start", 32'(mul_rst), 32'd1);
        check("bp_valid_clr", 32'(out_valid), 32'd0);
        check("bp_new_mcand", 32'(mul_multiplicand), 32'h02);
        wait_valid(ok);
        check("bp2_done", 32'(ok), 32'd1);
        check("bp2_product", 32'(out_product), 32'h000C);
        drain("bp2");

        // Stale done survives into SETTLE
        stale_mode = 1'b1;
        run_op("stale", 8'h10, 8'h10, 16'h0100);
        stale_mode = 1'b0;

        // Reset while waiting
        hang_mode = 1'b1;
        start_op(8'h09, 8'h09);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstw_out_valid", 32'(out_valid), 32'd0);
        check("rstw_in_ready", 32'(in_ready), 32'd1);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_mcand", 32'(mul_multiplicand), 32'd0);
        hang_mode = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("rstw_no_result", 32'(seen), 32'd0);
        run_op("after_rst", 8'hFF, 8'hFF, 16'h0001);

`ifdef BOOTH_TIMEOUT_EN
        hang_mode = 1'b1;
        start_op(8'h05, 8'h05);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        check("to_cycles", 32'(n), 32'd26);
        check("to_valid", 32'(out_valid), 32'd1);
        check("to_error", 32'(out_error), 32'd1);
        check("to_product", 32'(out_product), 32'h0000);
        drain("to");
        check("to_error_clr", 32'(out_error), 32'd0);
        hang_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
